// File: rtl/stone_drawer_if.sv
// Bus between the stone drawer and its environment (stone RAM, rope controller, VGA plotter).
// Signal directions are named from the drawer's point of view.
interface stone_drawer_if;
  logic        start_i;
  logic [3:0]  quantity_i;
  logic [31:0] ram_data_i;
  logic        draw_stone_flag_o;
  logic [3:0]  draw_index_o;
  logic [8:0]  vga_x_o;
  logic [7:0]  vga_y_o;
  logic [2:0]  colour_o;
  logic        plot_o;
  logic        done_o;

  modport master (
    output start_i, quantity_i, ram_data_i,
    input  draw_stone_flag_o, draw_index_o, vga_x_o, vga_y_o, colour_o, plot_o, done_o
  );

  modport slave (
    input  start_i, quantity_i, ram_data_i,
    output draw_stone_flag_o, draw_index_o, vga_x_o, vga_y_o, colour_o, plot_o, done_o
  );
endinterface

// File: rtl/stone_drawer.sv
// Walks the stone records in the shared RAM and plots each visible stone as a
// SIZE x SIZE square, clipped to the 320x240 screen.
module stone_drawer #(
  parameter int         SIZE        = 16,
  parameter logic [2:0] COL_STONE   = 3'b111,
  parameter logic [2:0] COL_GOLD    = 3'b110,
  parameter logic [2:0] COL_DIAMOND = 3'b011,
  parameter logic [2:0] COL_OTHER   = 3'b101
) (
  input  logic          clock,
  input  logic          resetn,
  stone_drawer_if.slave bus
);
  localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SET_ADDR = 3'd1;
  localparam logic [2:0] S_WAIT     = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_DRAW     = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  function automatic logic [2:0] colour_of(input logic [1:0] kind);
    case (kind)
      2'd0:    return COL_STONE;
      2'd1:    return COL_GOLD;
      2'd2:    return COL_DIAMOND;
      default: return COL_OTHER;
    endcase
  endfunction

  logic [2:0]    state_q, state_d;
  logic [3:0]    qty_q, qty_d;
  logic [3:0]    idx_q, idx_d;
  logic [8:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [1:0]    type_q, type_d;
  logic [CW-1:0] dx_q, dx_d;
  logic [CW-1:0] dy_q, dy_d;
  logic          flag_q, plot_q, done_q;
  logic [8:0]    vga_x_q;
  logic [7:0]    vga_y_q;
  logic [2:0]    colour_q;
  logic [9:0]    px_s;
  logic [8:0]    py_s;
  logic          plot_s;
  logic          unused_ok_s;

  assign unused_ok_s = ^{bus.ram_data_i[22:19], bus.ram_data_i[10:4], bus.ram_data_i[0]};

  // Next-state logic: record walk, square raster and pixel of the coming cycle
  always_comb begin
    state_d = state_q;
    qty_d   = qty_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    type_d  = type_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          qty_d   = bus.quantity_i;
          idx_d   = 4'd0;
          state_d = (bus.quantity_i == 4'd0) ? S_DONE : S_SET_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SET_ADDR: state_d = S_WAIT;
      S_WAIT:     state_d = S_LOAD;
      S_LOAD: begin
        x_d     = bus.ram_data_i[31:23];
        y_d     = bus.ram_data_i[18:11];
        type_d  = bus.ram_data_i[3:2];
        dx_d    = '0;
        dy_d    = '0;
        state_d = bus.ram_data_i[1] ? S_DRAW : S_NEXT;
      end
      S_DRAW: begin
        if (dx_q == LAST) begin
          dx_d = '0;
          if (dy_q == LAST) begin
            state_d = S_NEXT;
          end else begin
            dy_d = dy_q + CW'(1);
          end
        end else begin
          dx_d = dx_q + CW'(1);
        end
      end
      S_NEXT: begin
        // Index returns to 0 as the pass finishes so DONE shows the rest address
        if (({1'b0, idx_q} + 5'd1) >= {1'b0, qty_q}) begin
          idx_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_SET_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Wide sums so off-screen pixels are clipped rather than wrapped
    px_s   = {1'b0, x_d} + 10'(dx_d);
    py_s   = {1'b0, y_d} + 9'(dy_d);
    plot_s = (state_d == S_DRAW) && (px_s < 10'd320) && (py_s < 9'd240);
  end

  // State and output registers; every output comes straight from a flop
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      qty_q    <= 4'd0;
      idx_q    <= 4'd0;
      x_q      <= 9'd0;
      y_q      <= 8'd0;
      type_q   <= 2'd0;
      dx_q     <= '0;
      dy_q     <= '0;
      flag_q   <= 1'b0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      vga_x_q  <= 9'd0;
      vga_y_q  <= 8'd0;
      colour_q <= 3'd0;
    end else begin
      state_q <= state_d;
      qty_q   <= qty_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      type_q  <= type_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      flag_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      plot_q  <= plot_s;
      done_q  <= (state_d == S_DONE);
      if (plot_s) begin
        vga_x_q  <= px_s[8:0];
        vga_y_q  <= py_s[7:0];
        colour_q <= colour_of(type_d);
      end else begin
        vga_x_q  <= vga_x_q;
        vga_y_q  <= vga_y_q;
        colour_q <= colour_q;
      end
    end
  end

  assign bus.draw_stone_flag_o = flag_q;
  assign bus.draw_index_o      = idx_q;
  assign bus.vga_x_o           = vga_x_q;
  assign bus.vga_y_o           = vga_y_q;
  assign bus.colour_o          = colour_q;
  assign bus.plot_o            = plot_q;
  assign bus.done_o            = done_q;
endmodule

// File: tb/tb_stone_drawer.sv
// Self-checking bench for stone_drawer: directed vector table, random passes
// against a pixel-list model, and hand-written reset / re-start sequences.
module tb_stone_drawer;
  localparam int SIZE = 16;
  localparam int NV   = 8;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  typedef struct {
    logic [3:0]  qty;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [31:0] r2;
    int          exp_plots;
    int          exp_cycles;
    logic [8:0]  fx;
    logic [7:0]  fy;
    logic [2:0]  fcol;
  } vec_t;

  logic clock = 1'b0;
  logic resetn;
  stone_drawer_if bif ();

  stone_drawer #(.SIZE(SIZE)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bif)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [16];
  always @(posedge clock) bif.ram_data_i <= mem[bif.draw_index_o];

  int total = 0;
  int bad   = 0;
  logic [2:0] cols [4];
  vec_t tbl [NV];

  task automatic check_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [8:0] x, input logic [7:0] y,
                                     input logic [1:0] t, input logic v, input logic m);
    return {x, 4'b0000, y, 7'b0000000, t, v, m};
  endfunction

  // One full pass: model the expected pixel stream from the records, then run and compare.
  task automatic run_pass(input string nm, input logic [3:0] q, input int pulse_at,
                          input logic [3:0] mid_q, output int n_plots, output int n_cyc,
                          output pix_t first);
    pix_t expq[$];
    int   seq[$];
    int   exp_rec[16];
    int   rec_cyc[16];
    int   exp_cyc, xx, yy, pix_bad, flag_bad, seq_bad, rec_bad, post_bad, limit;
    logic [31:0] r;
    bit   got_done;
    pix_t got;

    exp_cyc = 2;
    for (int i = 0; i < 16; i++) begin
      exp_rec[i] = 0;
      rec_cyc[i] = 0;
    end
    for (int i = 0; i < int'(q); i++) begin
      r  = mem[i];
      xx = int'(r[31:23]);
      yy = int'(r[18:11]);
      exp_rec[i] = 4;
      if (r[1]) begin
        exp_rec[i] += SIZE * SIZE;
        for (int dy = 0; dy < SIZE; dy++)
          for (int dx = 0; dx < SIZE; dx++)
            if (xx + dx < 320 && yy + dy < 240)
              expq.push_back('{x: 9'(xx + dx), y: 8'(yy + dy), c: cols[r[3:2]]});
      end
      exp_cyc += exp_rec[i];
    end

    n_plots = 0; pix_bad = 0; flag_bad = 0; seq_bad = 0; rec_bad = 0; post_bad = 0;
    first = '0; got_done = 1'b0;
    limit = 40 + 16 * (4 + SIZE * SIZE);

    @(negedge clock);
    bif.start_i    = 1'b1;
    bif.quantity_i = q;
    n_cyc = 1;
    for (int k = 0; k < limit && !got_done; k++) begin
      @(negedge clock);
      n_cyc++;
      bif.start_i = (n_cyc == pulse_at);
      if (n_cyc == 3) bif.quantity_i = mid_q;
      if (bif.done_o === 1'b1) begin
        got_done = 1'b1;
        if (bif.draw_stone_flag_o !== 1'b0 || bif.plot_o !== 1'b0) flag_bad++;
      end else begin
        if (bif.draw_stone_flag_o !== 1'b1) begin
          flag_bad++;
        end else begin
          rec_cyc[bif.draw_index_o]++;
          if (seq.size() == 0 || seq[$] != int'(bif.draw_index_o))
            seq.push_back(int'(bif.draw_index_o));
        end
        if (bif.plot_o === 1'b1) begin
          got = '{x: bif.vga_x_o, y: bif.vga_y_o, c: bif.colour_o};
          if (n_plots == 0) first = got;
          if (n_plots >= expq.size() || got !== expq[n_plots]) pix_bad++;
          n_plots++;
        end
      end
    end
    bif.start_i = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (bif.done_o !== 1'b0 || bif.draw_stone_flag_o !== 1'b0 || bif.plot_o !== 1'b0)
        post_bad++;
    end

    if (seq.size() != int'(q)) seq_bad++;
    for (int i = 0; i < seq.size(); i++) if (seq[i] != i) seq_bad++;
    for (int i = 0; i < int'(q); i++) if (rec_cyc[i] != exp_rec[i]) rec_bad++;

    check_eq({nm, "_done_reached"}, 64'(got_done), 64'd1);
    check_eq({nm, "_cycles"}, 64'(n_cyc), 64'(exp_cyc));
    check_eq({nm, "_plot_count"}, 64'(n_plots), 64'(expq.size()));
    check_eq({nm, "_pixel_errors"}, 64'(pix_bad), 64'd0);
    check_eq({nm, "_flag_errors"}, 64'(flag_bad), 64'd0);
    check_eq({nm, "_index_seq_errors"}, 64'(seq_bad), 64'd0);
    check_eq({nm, "_record_cycle_errors"}, 64'(rec_bad), 64'd0);
    check_eq({nm, "_after_done_errors"}, 64'(post_bad), 64'd0);
  endtask

  initial begin
    int         np, nc, post_bad;
    pix_t       fp;
    logic [31:0] rec;
    logic [3:0] q;

    cols[0] = 3'b111; cols[1] = 3'b110; cols[2] = 3'b011; cols[3] = 3'b101;

    tbl[0] = '{4'd0, 32'd0, 32'd0, 32'd0, 0, 2, 9'd0, 8'd0, 3'd0};
    tbl[1] = '{4'd1, mk(9'd100, 8'd50, 2'd1, 1'b1, 1'b0), 32'd0, 32'd0, 256, 262, 9'd100, 8'd50, 3'b110};
    tbl[2] = '{4'd3, mk(9'd40, 8'd60, 2'd0, 1'b1, 1'b0), mk(9'd200, 8'd100, 2'd2, 1'b0, 1'b0),
               mk(9'd10, 8'd10, 2'd3, 1'b1, 1'b1), 512, 526, 9'd40, 8'd60, 3'b111};
    tbl[3] = '{4'd1, mk(9'd310, 8'd230, 2'd2, 1'b1, 1'b0), 32'd0, 32'd0, 100, 262, 9'd310, 8'd230, 3'b011};
    tbl[4] = '{4'd1, mk(9'd5, 8'd5, 2'd0, 1'b0, 1'b1), 32'd0, 32'd0, 0, 6, 9'd0, 8'd0, 3'd0};
    tbl[5] = '{4'd1, mk(9'd0, 8'd0, 2'd3, 1'b1, 1'b1), 32'd0, 32'd0, 256, 262, 9'd0, 8'd0, 3'b101};
    tbl[6] = '{4'd1, mk(9'd319, 8'd239, 2'd0, 1'b1, 1'b0), 32'd0, 32'd0, 1, 262, 9'd319, 8'd239, 3'b111};
    tbl[7] = '{4'd2, mk(9'd304, 8'd224, 2'd1, 1'b1, 1'b0), mk(9'd320, 8'd0, 2'd0, 1'b1, 1'b0),
               32'd0, 256, 522, 9'd304, 8'd224, 3'b110};

    for (int j = 0; j < 16; j++) mem[j] = 32'd0;
    resetn = 1'b0;
    bif.start_i = 1'b0;
    bif.quantity_i = 4'd0;
    repeat (3) @(negedge clock);
    check_eq("reset_outputs",
             64'({bif.draw_stone_flag_o, bif.draw_index_o, bif.vga_x_o, bif.vga_y_o,
                  bif.colour_o, bif.plot_o, bif.done_o}), 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      for (int j = 3; j < 16; j++) mem[j] = $urandom;
      mem[0] = tbl[i].r0;
      mem[1] = tbl[i].r1;
      mem[2] = tbl[i].r2;
      run_pass($sformatf("vec%0d", i), tbl[i].qty, 0, tbl[i].qty, np, nc, fp);
      check_eq($sformatf("vec%0d_table_plots", i), 64'(np), 64'(tbl[i].exp_plots));
      check_eq($sformatf("vec%0d_table_cycles", i), 64'(nc), 64'(tbl[i].exp_cycles));
      if (tbl[i].exp_plots > 0)
        check_eq($sformatf("vec%0d_first_pixel", i), 64'(fp), 64'({tbl[i].fx, tbl[i].fy, tbl[i].fcol}));
    end

    // Random passes with garbage in the unused record bits and stray mid-pass inputs
    for (int r = 0; r < 6; r++) begin
      q = 4'($urandom_range(0, 4));
      for (int j = 0; j < 16; j++) begin
        rec = $urandom;
        rec[31:23] = 9'($urandom_range(0, 330));
        rec[18:11] = 8'($urandom_range(0, 250));
        mem[j] = rec;
      end
      run_pass($sformatf("rand%0d", r), q, ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 200)) : 0,
               4'($urandom_range(0, 15)), np, nc, fp);
    end

    // Start re-pulsed during DRAW and quantity changed mid-pass
    mem[0] = mk(9'd50, 8'd50, 2'd2, 1'b1, 1'b0);
    mem[1] = mk(9'd80, 8'd20, 2'd1, 1'b1, 1'b1);
    run_pass("restart_in_draw", 4'd1, 30, 4'd1, np, nc, fp);
    run_pass("qty_change", 4'd2, 0, 4'd9, np, nc, fp);

    // Reset asserted mid-DRAW, then a fresh pass from index 0
    mem[0] = mk(9'd20, 8'd20, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    bif.start_i = 1'b1;
    bif.quantity_i = 4'd1;
    @(negedge clock);
    bif.start_i = 1'b0;
    repeat (40) @(negedge clock);
    check_eq("pre_reset_plot", 64'(bif.plot_o), 64'd1);
    resetn = 1'b0;
    @(negedge clock);
    check_eq("mid_draw_reset_outputs",
             64'({bif.draw_stone_flag_o, bif.draw_index_o, bif.vga_x_o, bif.vga_y_o,
                  bif.colour_o, bif.plot_o, bif.done_o}), 64'd0);
    post_bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (bif.done_o !== 1'b0 || bif.draw_stone_flag_o !== 1'b0) post_bad++;
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (bif.done_o !== 1'b0 || bif.draw_stone_flag_o !== 1'b0) post_bad++;
    end
    check_eq("reset_no_done", 64'(post_bad), 64'd0);
    run_pass("after_reset", 4'd1, 0, 4'd1, np, nc, fp);
    check_eq("after_reset_first_pixel", 64'(fp), 64'({9'd20, 8'd20, 3'b111}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stone_drawer.md
STONE_DRAWER -- requirements
Module: stone_drawer

Interface
REQ-001 Parameter SIZE, default 16: sprite edge length in pixels (square).
REQ-002 Parameters COL_STONE 3'b111, COL_GOLD 3'b110, COL_DIAMOND 3'b011, COL_OTHER 3'b101: colour per type code 0/1/2/3.
REQ-003 clock  input  1  system clock; all state changes on rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to redraw all stones; honoured only in IDLE.
REQ-006 quantity  input  4  number of stone records (indices 0..quantity-1); sampled when start is accepted.
REQ-007 ram_data  input  32  stone record from the shared stone RAM at draw_index.
REQ-008 draw_stone_flag  output  1  high while the block owns the RAM read address; the rope controller holds off while it is high.
REQ-009 draw_index  output  4  RAM address of the record being read.
REQ-010 vga_x  output  9  pixel column, 0..319.
REQ-011 vga_y  output  8  pixel row, 0..239.
REQ-012 colour  output  3  pixel colour.
REQ-013 plot  output  1  pixel write strobe; vga_x/vga_y/colour valid when high.
REQ-014 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-015 Record format: X = ram_data[31:23], Y = ram_data[18:11], type = ram_data[3:2], visible = ram_data[1], moving = ram_data[0].
REQ-016 States: IDLE, SET_ADDR, WAIT, LOAD, DRAW, NEXT, DONE.
REQ-017 IDLE: flag low; start=1 -> latch quantity, clear draw_index, go SET_ADDR; if latched quantity = 0, go DONE instead.
REQ-018 SET_ADDR (1 cycle): flag high, draw_index drives RAM address -> WAIT.
REQ-019 WAIT (1 cycle): covers 1-cycle RAM read latency -> LOAD.
REQ-020 LOAD (1 cycle): register X, Y, type, visible; clear dx, dy; visible=1 -> DRAW, else -> NEXT.
REQ-021 DRAW: one pixel per cycle, row-major, dx 0..SIZE-1 inner, dy 0..SIZE-1 outer; after dx=dy=SIZE-1 -> NEXT. Exactly SIZE*SIZE cycles.
REQ-022 Pixel coordinates: px = X+dx computed 10-bit, py = Y+dy computed 9-bit; no wrap.
REQ-023 Clipping: plot=1 only if px<320 and py<240; otherwise plot=0, counters still advance.
REQ-024 colour selected from latched type per REQ-002; moving stones drawn identically to static ones.
REQ-025 NEXT: draw_index+1; if new index >= latched quantity -> DONE, else -> SET_ADDR.
REQ-026 DONE (1 cycle): done=1, flag low, draw_index=0 -> IDLE.
REQ-027 draw_stone_flag high in SET_ADDR, WAIT, LOAD, DRAW, NEXT; low in IDLE and DONE.
REQ-028 plot=0 in every state except DRAW.
REQ-029 start outside IDLE ignored; quantity changes mid-pass ignored.
REQ-030 Pass length = 1 + sum over records (4 cycles, +SIZE*SIZE if visible) + 1 cycles from start to done.
REQ-031 All outputs registered; no combinational path from any input to any output.

Reset
REQ-032 resetn=0 at a rising edge -> IDLE next cycle, regardless of state, including mid-DRAW.
REQ-033 Reset values: draw_stone_flag 0, draw_index 0, vga_x 0, vga_y 0, colour 0, plot 0, done 0, latched quantity 0.
REQ-034 No done pulse produced by reset.

Verification
REQ-035 quantity=0, start -> done pulse 2 cycles after start, plot never high, flag never high.
REQ-036 quantity=1, record X=100,Y=50,type=1,visible=1 -> 256 plots colour 3'b110, first (100,50), last (115,65), flag high throughout, done after.
REQ-037 quantity=3, records 0 and 2 visible, record 1 with bits[1:0]=00 -> 512 plots, draw_index sequence 0,1,2, record 1 consumes exactly 4 cycles.
REQ-038 Record X=310,Y=230 visible -> 256 DRAW cycles, plot high only for px<=319 and py<=239 (100 pixels).
REQ-039 Assert resetn=0 mid-DRAW of record 0 -> next cycle all outputs at reset values, no done; new start redraws from index 0.
REQ-040 start pulsed again during DRAW -> ignored; exactly one done for the pass.
